// File: rtl/pc_pkg.sv
// pc_pkg: shared state/select encodings and default vectors for the fetch PC
package pc_pkg;
    typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
    typedef enum logic [2:0] {HOLD, SEQ, REDIR, PEND, EXC, ERET} sel_t;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0040_0000;
    localparam logic [31:0] DEF_EXC_VEC = 32'h0040_0004;
endpackage

// File: rtl/pc_fetch_ctrl_next_sel.sv
// pc_next_sel: next-PC priority mux with misaligned-target detection
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int ALIGN_BITS = 2,
    parameter logic [ADDR_W-1:0] EXC_VEC = DEF_EXC_VEC
) (
    input  state_t            state,
    input  logic              stall,
    input  logic              accept,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_target,
    input  logic              pend_valid,
    input  logic [ADDR_W-1:0] pend_target,
    input  logic              exc_req,
    input  logic              eret_req,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] pc_next_seq,
    input  logic [ADDR_W-1:0] epc,
    output sel_t              sel,
    output logic [ADDR_W-1:0] pc_d,
    output logic              buf_wr,
    output logic              fault
);
    localparam logic [ADDR_W-1:0] MASK = (ADDR_W'(1) << ALIGN_BITS) - ADDR_W'(1);
    logic [ADDR_W-1:0] tgt;
    logic take;
    // Priority: exception, eret, redirect (new over pending), sequential, hold; FAULT only honours exceptions
    always_comb begin
        tgt = redir_valid ? redir_target : pend_target;
        take = accept || !stall;
        sel = state == BOOT ? HOLD :
              exc_req ? EXC :
              state != RUN ? HOLD :
              eret_req ? ERET :
              !(redir_valid || pend_valid) ? (accept ? SEQ : HOLD) :
              !take ? HOLD :
              redir_valid ? REDIR : PEND;
        buf_wr = state == RUN && sel == HOLD && redir_valid;
        pc_d = sel == SEQ ? pc_next_seq :
               (sel == REDIR || sel == PEND) ? tgt :
               sel == EXC ? EXC_VEC :
               sel == ERET ? epc : pc;
        fault = (sel == REDIR || sel == PEND || sel == ERET) && (pc_d & MASK) != '0;
    end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch PC register, IMEM request handshake, redirect buffering and fault FSM
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = DEF_RESET_VEC,
    parameter logic [ADDR_W-1:0] EXC_VEC = DEF_EXC_VEC,
    parameter int ALIGN_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_target,
    input  logic              exc_req,
    input  logic              eret_req,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next_seq,
    output logic [ADDR_W-1:0] epc,
    output logic              redir_pending,
    output logic              align_fault
);
    state_t state, state_n;
    sel_t sel;
    logic [ADDR_W-1:0] pc_d, pend_target;
    logic buf_wr, fault, accept;
    assign pc_next_seq = pc + (ADDR_W'(1) << ALIGN_BITS);
    assign req_valid = state == RUN && !stall;
    assign accept = req_valid && req_ready;
    assign align_fault = state == FAULT;
    pc_next_sel #(.ADDR_W(ADDR_W), .ALIGN_BITS(ALIGN_BITS), .EXC_VEC(EXC_VEC)) u_sel (
        .state(state),
        .stall(stall),
        .accept(accept),
        .redir_valid(redir_valid),
        .redir_target(redir_target),
        .pend_valid(redir_pending),
        .pend_target(pend_target),
        .exc_req(exc_req),
        .eret_req(eret_req),
        .pc(pc),
        .pc_next_seq(pc_next_seq),
        .epc(epc),
        .sel(sel),
        .pc_d(pc_d),
        .buf_wr(buf_wr),
        .fault(fault)
    );
    // BOOT lasts one cycle; a misaligned load halts fetch until an exception
    always_comb begin
        state_n = state == BOOT ? RUN : sel == EXC ? RUN : fault ? FAULT : state;
    end
    // PC, EPC, redirect buffer and state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
            pc <= RESET_VEC;
            epc <= '0;
            redir_pending <= 1'b0;
            pend_target <= '0;
        end else begin
            state <= state_n;
            pc <= pc_d;
            if (sel == EXC) epc <= pc;
            if (buf_wr) begin
                redir_pending <= 1'b1;
                pend_target <= redir_target;
            end else if (sel inside {REDIR, PEND, EXC, ERET}) begin
                redir_pending <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed vector table plus randomized run against a spec-level model
module tb_pc_fetch_ctrl;
    import pc_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall = 1'b0, redir_valid = 1'b0, exc_req = 1'b0, eret_req = 1'b0, req_ready = 1'b1;
    logic [31:0] redir_target = '0;
    logic req_valid, redir_pending, align_fault;
    logic [31:0] pc, pc_next_seq, epc;
    int checks = 0;
    int errors = 0;
    logic [31:0] m_pc, m_epc, m_ptgt;
    logic m_pend;
    int m_mode;

    typedef struct {
        logic st, rv;
        logic [31:0] rt;
        logic ex, er, rdy;
        logic e_rv;
        logic [31:0] e_pc, e_epc;
        logic e_pend, e_flt;
    } vec_t;
    vec_t vecs[$];

    pc_fetch_ctrl dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .redir_valid(redir_valid),
        .redir_target(redir_target),
        .exc_req(exc_req),
        .eret_req(eret_req),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .pc(pc),
        .pc_next_seq(pc_next_seq),
        .epc(epc),
        .redir_pending(redir_pending),
        .align_fault(align_fault)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic st, rv, input logic [31:0] rt, input logic ex, er, rdy,
                                input logic e_rv, input logic [31:0] e_pc, e_epc, input logic e_pend, e_flt);
        vec_t v;
        v.st = st; v.rv = rv; v.rt = rt; v.ex = ex; v.er = er; v.rdy = rdy;
        v.e_rv = e_rv; v.e_pc = e_pc; v.e_epc = e_epc; v.e_pend = e_pend; v.e_flt = e_flt;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic st, rv, input logic [31:0] rt, input logic ex, er, rdy);
        stall = st; redir_valid = rv; redir_target = rt; exc_req = ex; eret_req = er; req_ready = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour straight from the priority rules: mode 0=boot, 1=run, 2=fault
    task automatic mstep(input logic st, rv, input logic [31:0] rt, input logic ex, er, rdy);
        logic acc;
        logic [31:0] t;
        acc = m_mode == 1 && !st && rdy;
        if (m_mode == 0) m_mode = 1;
        else if (ex) begin
            m_epc = m_pc; m_pc = DEF_EXC_VEC; m_pend = 0; m_mode = 1;
        end else if (m_mode == 1) begin
            if (er) begin
                m_pc = m_epc; m_pend = 0;
                if (m_pc % 4 != 0) m_mode = 2;
            end else if (rv || m_pend) begin
                t = rv ? rt : m_ptgt;
                if (acc || !st) begin
                    m_pc = t; m_pend = 0;
                    if (t % 4 != 0) m_mode = 2;
                end else begin
                    m_pend = 1; m_ptgt = t;
                end
            end else if (acc) m_pc = m_pc + 4;
        end
    endtask

    initial begin
        // st rv target      ex er rdy | req_valid pc epc pend fault
        add(0,0,32'h0,       0,0,1, 1, 32'h00400004, 32'h0,        0,0);
        add(0,0,32'h0,       0,0,1, 1, 32'h00400008, 32'h0,        0,0);
        add(0,0,32'h0,       0,0,0, 1, 32'h00400008, 32'h0,        0,0);
        add(0,0,32'h0,       0,0,0, 1, 32'h00400008, 32'h0,        0,0);
        add(0,0,32'h0,       0,0,0, 1, 32'h00400008, 32'h0,        0,0);
        add(0,0,32'h0,       0,0,1, 1, 32'h0040000C, 32'h0,        0,0);
        add(0,0,32'h0,       0,0,1, 1, 32'h00400010, 32'h0,        0,0);
        add(0,1,32'h00400300,1,0,1, 1, 32'h00400004, 32'h00400010, 0,0);
        add(0,0,32'h0,       0,1,1, 1, 32'h00400010, 32'h00400010, 0,0);
        add(1,1,32'h00400100,0,0,1, 0, 32'h00400010, 32'h00400010, 1,0);
        add(1,0,32'h0,       0,0,1, 0, 32'h00400010, 32'h00400010, 1,0);
        add(1,1,32'h00400200,0,0,1, 0, 32'h00400010, 32'h00400010, 1,0);
        add(0,0,32'h0,       0,0,0, 1, 32'h00400200, 32'h00400010, 0,0);
        add(0,0,32'h0,       0,0,1, 1, 32'h00400204, 32'h00400010, 0,0);
        add(0,1,32'h00400102,0,0,1, 1, 32'h00400102, 32'h00400010, 0,1);
        for (int i = 0; i < 5; i++) add(0,0,32'h0,0,0,1, 0, 32'h00400102, 32'h00400010, 0,1);
        add(0,0,32'h0,       1,0,1, 0, 32'h00400004, 32'h00400102, 0,0);
        add(0,0,32'h0,       0,0,1, 1, 32'h00400008, 32'h00400102, 0,0);
        add(0,1,32'hFFFFFFFC,0,0,1, 1, 32'hFFFFFFFC, 32'h00400102, 0,0);
        add(0,0,32'h0,       0,0,1, 1, 32'h00000000, 32'h00400102, 0,0);

        #12 rst = 1'b0;
        #1;
        chk("reset pc", pc, 32'h00400000);
        chk("reset req_valid", req_valid, 0);
        chk("reset epc", epc, 0);
        chk("reset pending", redir_pending, 0);
        chk("reset fault", align_fault, 0);
        tick();
        chk("boot pc", pc, 32'h00400000);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].st, vecs[i].rv, vecs[i].rt, vecs[i].ex, vecs[i].er, vecs[i].rdy);
            chk($sformatf("v%0d req_valid", i), req_valid, vecs[i].e_rv);
            tick();
            chk($sformatf("v%0d pc", i), pc, vecs[i].e_pc);
            chk($sformatf("v%0d epc", i), epc, vecs[i].e_epc);
            chk($sformatf("v%0d pending", i), redir_pending, vecs[i].e_pend);
            chk($sformatf("v%0d fault", i), align_fault, vecs[i].e_flt);
        end

        apply(1, 1, 32'h00400500, 0, 0, 1);
        tick();
        chk("pre-reset pending", redir_pending, 1);
        apply(1, 0, 32'h0, 0, 0, 1);
        #2 rst = 1'b1;
        #1;
        chk("async rst pc", pc, 32'h00400000);
        chk("async rst pending", redir_pending, 0);
        chk("async rst epc", epc, 0);
        chk("async rst req_valid", req_valid, 0);
        #3 rst = 1'b0;
        m_pc = DEF_RESET_VEC; m_epc = '0; m_ptgt = '0; m_pend = 0; m_mode = 0;
        apply(0, 0, 32'h0, 0, 0, 1);
        chk("post-reset boot req_valid", req_valid, 0);
        tick();
        mstep(0, 0, 32'h0, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            logic st, rv, ex, er, rdy;
            logic [31:0] rt;
            st = $urandom_range(0, 9) < 3;
            rv = $urandom_range(0, 9) < 2;
            ex = $urandom_range(0, 99) < 3;
            er = $urandom_range(0, 99) < 5;
            rdy = $urandom_range(0, 9) < 7;
            rt = $urandom;
            if ($urandom_range(0, 15) != 0) rt = rt & 32'hFFFFFFFC;
            apply(st, rv, rt, ex, er, rdy);
            chk("rnd req_valid", req_valid, m_mode == 1 && !st);
            chk("rnd pc_next_seq", pc_next_seq, m_pc + 32'd4);
            tick();
            mstep(st, rv, rt, ex, er, rdy);
            chk("rnd pc", pc, m_pc);
            chk("rnd epc", epc, m_epc);
            chk("rnd pending", redir_pending, m_pend);
            chk("rnd fault", align_fault, m_mode == 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
